// File: rtl/imm_pkg.sv
// imm_pkg: immediate-select encodings, widths and FIFO entry layout
package imm_pkg;
    localparam int XLEN = 32;
    localparam int TAG_W = 5;
    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_U = 3'b011;
    localparam logic [2:0] IMM_J = 3'b100;
    typedef struct packed {
        logic [XLEN-1:0]  imm;
        logic             illegal;
        logic [TAG_W-1:0] tag;
    } entry_t;
endpackage

// File: rtl/imm_gen_core.sv
// imm_gen_core: combinational RV32 immediate former
module imm_gen_core
    import imm_pkg::*;
(
    input  logic [XLEN-1:0] instr,
    input  logic [2:0]      imm_sel,
    output logic [XLEN-1:0] imm,
    output logic            illegal
);
    always_comb begin
        imm = '0;
        illegal = 1'b0;
        case (imm_sel)
            IMM_I: imm = {{20{instr[31]}}, instr[31:20]};
            IMM_S: imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B: imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U: imm = {instr[31:12], 12'h000};
            IMM_J: imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: illegal = 1'b1;
        endcase
    end
endmodule

// File: rtl/imm_gen_stage.sv
// imm_gen_stage: immediate decode into a 2-entry FIFO with handshakes and illegal-select counter
module imm_gen_stage
    import imm_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  instr,
    input  logic [2:0]       imm_sel,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  imm,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag,
    output logic [7:0]       illegal_cnt
);
    logic [1:0]      count;
    logic            wptr, rptr;
    entry_t          mem [2];
    logic [XLEN-1:0] dec_imm;
    logic            dec_illegal;
    logic            push, pop;

    imm_gen_core u_core (
        .instr   (instr),
        .imm_sel (imm_sel),
        .imm     (dec_imm),
        .illegal (dec_illegal)
    );

    // in_ready depends only on count, so out_ready never reaches it combinationally
    assign in_ready    = count != 2'd2;
    assign out_valid   = count != 2'd0;
    assign push        = in_valid & in_ready & ~flush;
    assign pop         = out_valid & out_ready & ~flush;
    assign imm         = mem[rptr].imm;
    assign out_illegal = mem[rptr].illegal;
    assign out_tag     = mem[rptr].tag;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= 2'd0;
            wptr <= 1'b0;
            rptr <= 1'b0;
            illegal_cnt <= 8'd0;
        end else begin
            if (flush) begin
                count <= 2'd0;
                wptr <= 1'b0;
                rptr <= 1'b0;
            end else begin
                count <= count + {1'b0, push} - {1'b0, pop};
                wptr <= wptr ^ push;
                rptr <= rptr ^ pop;
            end
            if (push && dec_illegal && illegal_cnt != 8'hFF)
                illegal_cnt <= illegal_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wptr] <= '{imm: dec_imm, illegal: dec_illegal, tag: in_tag};
    end
endmodule

// File: tb/tb_imm_gen_stage.sv
// tb_imm_gen_stage: randomized scoreboard bench for imm_gen_stage against a field-arithmetic reference model
module tb_imm_gen_stage;
    typedef struct {
        logic [31:0] imm;
        logic        ill;
        logic [4:0]  tag;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] instr = '0;
    logic [2:0]  imm_sel = '0;
    logic [4:0]  in_tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] imm;
    logic        out_illegal;
    logic [4:0]  out_tag;
    logic [7:0]  illegal_cnt;

    exp_t q[$];
    int   ill_model = 0;
    int   checks = 0;
    int   fails = 0;
    bit   run = 0;

    imm_gen_stage dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .instr       (instr),
        .imm_sel     (imm_sel),
        .in_tag      (in_tag),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .imm         (imm),
        .out_illegal (out_illegal),
        .out_tag     (out_tag),
        .illegal_cnt (illegal_cnt)
    );

    always #5 clk = ~clk;

    // Immediate rebuilt from bit weights and arithmetic shifts of the whole word
    function automatic exp_t model(logic [31:0] w, logic [2:0] sel, logic [4:0] tag);
        exp_t e;
        logic [31:0] s20, s31, s25;
        s20 = $unsigned($signed(w) >>> 20);
        s25 = $unsigned($signed(w) >>> 25);
        s31 = $unsigned($signed(w) >>> 31);
        e.ill = sel > 3'd4;
        e.tag = tag;
        case (sel)
            3'd0: e.imm = s20;
            3'd1: e.imm = (s25 << 5) | ((w >> 7) & 32'h1F);
            3'd2: e.imm = (s31 << 12) | (((w >> 7) & 1) << 11) | (((w >> 25) & 32'h3F) << 5) | (((w >> 8) & 32'hF) << 1);
            3'd3: e.imm = w & 32'hFFFFF000;
            3'd4: e.imm = (s31 << 20) | (((w >> 12) & 32'hFF) << 12) | (((w >> 20) & 1) << 11) | (((w >> 21) & 32'h3FF) << 1);
            default: e.imm = 32'h0;
        endcase
        return e;
    endfunction

    task automatic chk(string name, logic [31:0] got, logic [31:0] want);
        checks++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
        end
    endtask

    // One clock: record the handshake the coming edge will perform, then return just after that edge
    task automatic step();
        @(negedge clk);
        #1;
        if (!rst_n) begin
            q.delete();
            ill_model = 0;
        end else if (flush) begin
            q.delete();
        end else if (in_valid && in_ready) begin
            q.push_back(model(instr, imm_sel, in_tag));
            if (imm_sel > 3'd4 && ill_model < 255) ill_model++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic offer(logic v, logic [31:0] w, logic [2:0] sel, logic [4:0] tag);
        in_valid = v;
        instr = w;
        imm_sel = sel;
        in_tag = tag;
    endtask

    always @(negedge clk) begin
        if (run && rst_n) begin
            chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
            chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
            chk("illegal_cnt", 32'(illegal_cnt), 32'(ill_model));
            if (out_valid && out_ready && !flush && q.size() > 0) begin
                exp_t e;
                e = q.pop_front();
                chk("head_imm", imm, e.imm);
                chk("head_illegal", 32'(out_illegal), 32'(e.ill));
                chk("head_tag", 32'(out_tag), 32'(e.tag));
            end
        end
    end

    initial begin
        repeat (2) step();
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_illegal_cnt", 32'(illegal_cnt), 32'd0);
        rst_n = 1'b1;
        run = 1;

        out_ready = 1'b1;
        offer(1, 32'hFFF00093, 3'd0, 5'd1);
        step();
        offer(0, 32'h0, 3'd0, 5'd0);
        chk("i_type_imm", imm, 32'hFFFFFFFF);
        chk("i_type_illegal", 32'(out_illegal), 32'd0);
        step();
        offer(1, 32'hFE000EE3, 3'd2, 5'd2);
        step();
        chk("b_type_imm", imm, 32'hFFFFFFFC);
        offer(1, 32'h123450B7, 3'd3, 5'd3);
        step();
        offer(0, 32'h0, 3'd0, 5'd0);
        chk("u_type_imm", imm, 32'h12345000);
        step();

        out_ready = 1'b0;
        offer(1, 32'h0080006F, 3'd4, 5'd4);
        step();
        offer(1, 32'hFFF00093, 3'd0, 5'd5);
        step();
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        chk("bp_head_imm", imm, 32'h00000008);
        offer(1, 32'h123450B7, 3'd3, 5'd6);
        step();
        chk("bp_hold_imm", imm, 32'h00000008);
        chk("bp_hold_tag", 32'(out_tag), 32'd4);
        out_ready = 1'b1;
        step();
        offer(0, 32'h0, 3'd0, 5'd0);
        chk("bp_second_imm", imm, 32'hFFFFFFFF);
        repeat (3) step();
        chk("bp_drained", 32'(out_valid), 32'd0);

        for (int i = 0; i < 300; i++) begin
            offer(1, $urandom, 3'd7, 5'(i));
            step();
        end
        offer(0, 32'h0, 3'd0, 5'd0);
        repeat (2) step();
        chk("illegal_saturated", 32'(illegal_cnt), 32'hFF);

        out_ready = 1'b0;
        offer(1, 32'h00500013, 3'd0, 5'd7);
        repeat (2) step();
        chk("full_before_flush", 32'(in_ready), 32'd0);
        flush = 1'b1;
        offer(1, 32'h00600013, 3'd7, 5'd8);
        step();
        flush = 1'b0;
        offer(0, 32'h0, 3'd0, 5'd0);
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        chk("flush_in_ready", 32'(in_ready), 32'd1);
        chk("flush_keeps_cnt", 32'(illegal_cnt), 32'hFF);

        for (int i = 0; i < 2000; i++) begin
            offer(1'($urandom_range(0, 3) != 0), $urandom, 3'($urandom_range(0, 7)), 5'($urandom));
            out_ready = 1'($urandom_range(0, 2) != 0);
            flush = 1'($urandom_range(0, 40) == 0);
            step();
        end
        flush = 1'b0;

        out_ready = 1'b0;
        offer(1, 32'h0080006F, 3'd5, 5'd9);
        step();
        rst_n = 1'b0;
        out_ready = 1'b1;
        step();
        rst_n = 1'b1;
        offer(0, 32'h0, 3'd0, 5'd0);
        chk("midreset_out_valid", 32'(out_valid), 32'd0);
        chk("midreset_in_ready", 32'(in_ready), 32'd1);
        chk("midreset_illegal_cnt", 32'(illegal_cnt), 32'd0);
        repeat (2) step();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
